// File: rtl/gray_arb.sv
// gray_arb: two-master round-robin arbiter in front of a zero-latency grayscale image memory.
// Define GRAY_ARB_STAT_EN to add saturating per-master read counters (m0_cnt / m1_cnt).
module gray_arb #(
    parameter int MAX_BURST = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic [13:0] m0_addr,
    output logic        m0_gnt,
    output logic [7:0]  m0_data,
    output logic        m0_dvalid,
    input  logic        m1_req,
    input  logic [13:0] m1_addr,
    output logic        m1_gnt,
    output logic [7:0]  m1_data,
    output logic        m1_dvalid,
    input  logic        gray_ready,
    output logic        gray_req,
    output logic [13:0] gray_addr,
    input  logic [7:0]  gray_data
`ifdef GRAY_ARB_STAT_EN
    ,
    output logic [15:0] m0_cnt,
    output logic [15:0] m1_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state, state_nxt;
    logic       last_owner, last_owner_nxt;
    logic [3:0] burst_cnt, burst_cnt_nxt;
    logic       armed;
    logic       owning;
    logic       own_req, other_req, release_own;

    // armed holds off arbitration for one edge after reset so the first grant lands on the second edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= 4'd0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
            armed      <= 1'b1;
        end
    end

    always_comb begin
        owning         = (state == OWN0) || (state == OWN1);
        own_req        = (state == OWN1) ? m1_req : m0_req;
        other_req      = (state == OWN1) ? m0_req : m1_req;
        // staying put implies a dvalid this cycle, so the burst limit only needs the counter and the rival
        release_own    = !own_req || !gray_ready || ((burst_cnt == BURST_LAST) && other_req);

        state_nxt      = state;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;
        m0_gnt         = (state == OWN0);
        m1_gnt         = (state == OWN1);
        gray_req       = owning;
        gray_addr      = 14'd0;
        m0_data        = 8'd0;
        m1_data        = 8'd0;
        m0_dvalid      = 1'b0;
        m1_dvalid      = 1'b0;

        case (state)
            IDLE: begin
                if (armed && gray_ready && (m0_req || m1_req)) begin
                    burst_cnt_nxt = 4'd0;
                    state_nxt     = (m0_req && (!m1_req || last_owner)) ? OWN0 : OWN1;
                end
            end
            OWN0: begin
                gray_addr = m0_addr;
                m0_data   = gray_data;
                m0_dvalid = m0_req & gray_ready;
            end
            OWN1: begin
                gray_addr = m1_addr;
                m1_data   = gray_data;
                m1_dvalid = m1_req & gray_ready;
            end
            default: state_nxt = IDLE;
        endcase

        if (owning) begin
            if (release_own) begin
                last_owner_nxt = (state == OWN1);
                burst_cnt_nxt  = 4'd0;
                if (other_req && gray_ready) begin
                    state_nxt = (state == OWN0) ? OWN1 : OWN0;
                end else begin
                    state_nxt = IDLE;
                end
            end else begin
                burst_cnt_nxt = (burst_cnt == BURST_LAST) ? 4'd0 : burst_cnt + 4'd1;
            end
        end
    end

`ifdef GRAY_ARB_STAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_cnt <= 16'd0;
            m1_cnt <= 16'd0;
        end else begin
            if (m0_dvalid && (m0_cnt != 16'hFFFF)) m0_cnt <= m0_cnt + 16'd1;
            if (m1_dvalid && (m1_cnt != 16'hFFFF)) m1_cnt <= m1_cnt + 16'd1;
        end
    end
`endif

endmodule
